// File: rtl/seq_datapath_pkg.sv
// Shared opcode/state encodings and constants for the multi-cycle datapath.
package seq_datapath_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHRA = 4'd7,
    OP_SHL  = 4'd8,
    OP_ROR  = 4'd9,
    OP_ROL  = 4'd10,
    OP_NEG  = 4'd11,
    OP_NOT  = 4'd12,
    OP_LDI  = 4'd13,
    OP_NOP0 = 4'd14,
    OP_NOP1 = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_Y,
    ST_EXEC,
    ST_DIV_ITER,
    ST_WRITE
  } state_e;

  localparam logic [3:0] NOP_MIN = 4'd14;

  // Divide by zero yields a quotient of this bit replicated across the word.
  localparam logic DIV0_QUOT_BIT = 1'b1;

  function automatic logic is_nop(input logic [3:0] op);
    return op >= NOP_MIN;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative signed restoring divider: magnitudes in, one quotient bit per cycle,
// sign fix-up on the outputs. Busy for exactly WIDTH cycles after start.
module div_iter
  import seq_datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic             neg_q, neg_r;
  logic [WIDTH:0]   r_sh, diff;

  always_comb begin
    r_sh = {rem_q, quo_q[WIDTH-1]};
    diff = r_sh - {1'b0, dsr_q};
  end

  assign done      = busy && (cnt == '0);
  assign quotient  = neg_q ? -quo_q : quo_q;
  assign remainder = neg_r ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy  <= 1'b0;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      cnt   <= CW'(WIDTH - 1);
      rem_q <= '0;
      quo_q <= dividend[WIDTH-1] ? -dividend : dividend;
      dsr_q <= divisor[WIDTH-1] ? -divisor : divisor;
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end else if (busy) begin
      // Negative trial difference means restore (keep the shifted remainder).
      if (diff[WIDTH]) begin
        rem_q <= r_sh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/seq_datapath.sv
// Multi-cycle datapath: register file, Y/Z staging, HI/LO, ALU and divider,
// sequenced per command as Y load, execute (or divide), writeback.
//   state       | meaning
//   ST_IDLE     | cmd_ready high, waiting for a command
//   ST_LOAD_Y   | Y <= R[ra]; divider started for DIV
//   ST_EXEC     | Z <= ALU(Y, R[rb])
//   ST_DIV_ITER | divider iterating, WIDTH cycles
//   ST_WRITE    | commit result to R[rd] or HI/LO and flags
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  NREGS = 16,
  localparam int AW    = $clog2(NREGS),
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             carry,
  output logic             zero,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e state, state_nx;

  op_e              op_q;
  logic [AW-1:0]    rd_q, ra_q, rb_q;
  logic [WIDTH-1:0] imm_q;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] y, z_hi, z_lo;
  logic             z_carry;

  logic [WIDTH-1:0]   alu_a, alu_b, alu_lo, alu_hi;
  logic               alu_carry;
  logic [SW-1:0]      sh;
  logic [SW:0]        sh_inv;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  logic             accept, div_start, div_busy, div_done, div_by_zero;
  logic [WIDTH-1:0] div_q, div_r, div_quot, div_rem;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign dbg_data  = regs[dbg_addr];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (accept) state_nx = ST_LOAD_Y;
      ST_LOAD_Y:   state_nx = (op_q == OP_DIV) ? ST_DIV_ITER : ST_EXEC;
      ST_EXEC:     state_nx = ST_WRITE;
      ST_DIV_ITER: if (div_done || !div_busy) state_nx = ST_WRITE;
      ST_WRITE:    state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_q  <= OP_AND;
      rd_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= op_e'(cmd_op);
      rd_q  <= cmd_rd;
      ra_q  <= cmd_ra;
      rb_q  <= cmd_rb;
      imm_q <= cmd_imm;
    end
  end

  always_comb begin
    alu_a     = y;
    alu_b     = regs[rb_q];
    sh        = alu_b[SW-1:0];
    sh_inv    = (SW+1)'(WIDTH) - {1'b0, sh};
    sum       = '0;
    prod      = '0;
    alu_lo    = '0;
    alu_hi    = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_AND: alu_lo = alu_a & alu_b;
      OP_OR:  alu_lo = alu_a | alu_b;
      OP_ADD: begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_lo    = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        sum       = {1'b0, alu_a} + {1'b0, ~alu_b} + (WIDTH+1)'(1);
        alu_lo    = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_MUL: begin
        // Low 2W bits of the sign-extended product equal the signed product.
        prod   = {{WIDTH{alu_a[WIDTH-1]}}, alu_a} * {{WIDTH{alu_b[WIDTH-1]}}, alu_b};
        alu_hi = prod[2*WIDTH-1:WIDTH];
        alu_lo = prod[WIDTH-1:0];
      end
      OP_SHR:  alu_lo = alu_a >> sh;
      OP_SHRA: alu_lo = $signed(alu_a) >>> sh;
      OP_SHL:  alu_lo = alu_a << sh;
      OP_ROR:  alu_lo = (alu_a >> sh) | (alu_a << sh_inv);
      OP_ROL:  alu_lo = (alu_a << sh) | (alu_a >> sh_inv);
      OP_NEG:  alu_lo = -alu_b;
      OP_NOT:  alu_lo = ~alu_b;
      OP_LDI:  alu_lo = imm_q;
      default: alu_lo = '0;
    endcase
  end

  assign div_start   = (state == ST_LOAD_Y) && (op_q == OP_DIV);
  assign div_by_zero = (regs[rb_q] == '0);
  assign div_quot    = div_by_zero ? {WIDTH{DIV0_QUOT_BIT}} : div_q;
  assign div_rem     = div_by_zero ? y : div_r;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .clr       (clr),
    .start     (div_start),
    .dividend  (regs[ra_q]),
    .divisor   (regs[rb_q]),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      y       <= '0;
      z_hi    <= '0;
      z_lo    <= '0;
      z_carry <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == ST_WRITE);
      case (state)
        ST_LOAD_Y: y <= regs[ra_q];
        ST_EXEC: begin
          z_hi    <= alu_hi;
          z_lo    <= alu_lo;
          z_carry <= alu_carry;
        end
        ST_WRITE: begin
          if (op_q == OP_MUL) begin
            hi    <= z_hi;
            lo    <= z_lo;
            zero  <= ({z_hi, z_lo} == '0);
            carry <= 1'b0;
          end else if (op_q == OP_DIV) begin
            hi    <= div_rem;
            lo    <= div_quot;
            zero  <= (div_quot == '0);
            carry <= 1'b0;
          end else if (!is_nop(op_q)) begin
            regs[rd_q] <= z_lo;
            if (op_q != OP_LDI) begin
              zero  <= (z_lo == '0);
              carry <= z_carry;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised multi-cycle CPU datapath: a WIDTH-bit register file of NREGS registers, Y/Z staging registers, HI/LO, and a full ALU. An internal micro-sequencer runs each three-operand command (rd = ra op rb) through the bus steps Y load, execute and writeback, with a valid/ready command handshake and a done pulse. It adds an iterative signed divider and status flags, and it is the datapath the control unit drives next.

## Interface
- WIDTH, 32, datapath width in bits (≥ 8, power of two)
- NREGS, 16, register-file depth (power of two); AW = $clog2(NREGS), SW = $clog2(WIDTH) are derived
- clk  in  1  clock, rising edge
- clr  in  1  reset; one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  4  opcode
- cmd_rd, cmd_ra, cmd_rb  in  AW each  register indices
- cmd_imm  in  WIDTH  immediate for LDI
- done  out  1  one-cycle pulse when a command retires
- hi, lo  out  WIDTH each  HI/LO registers
- carry, zero  out  1 each  status flags
- dbg_addr  in  AW  debug read index
- dbg_data  out  WIDTH  combinational R[dbg_addr]

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHRA, 8 SHL, 9 ROR, 10 ROL, 11 NEG, 12 NOT, 13 LDI.
  - 14 and 15 are NOP: full 4-cycle sequence, no register or flag writes, done still pulses.
- Accept on cmd_valid && cmd_ready. All command fields are captured at accept; cmd_valid while busy is ignored.
- States:
  - IDLE → LOAD_Y: Y ← R[ra].
  - LOAD_Y → EXEC, or DIV_ITER if op = DIV.
  - EXEC → WRITE.
  - DIV_ITER (WIDTH cycles) → WRITE.
  - WRITE → IDLE.
- EXEC computes Z ← ALU(Y, R[rb]). LDI sets Z ← cmd_imm. NEG and NOT use R[rb] only.
- Shifts and rotates use the amount R[rb][SW-1:0]. SHRA is sign-filling.
- MUL: signed 2·WIDTH product; ZHI/ZLO are written in EXEC, and WRITE sets HI ← ZHI, LO ← ZLO.
- DIV:
  - Signed restoring division on magnitudes, with sign fix-up. Quotient truncates toward zero; remainder takes the sign of the dividend.
  - WRITE sets LO ← quotient, HI ← remainder.
  - Divide by zero gives LO = all-ones, HI = ra value.
- All other ops: WRITE sets R[rd] ← ZLO. HI/LO are untouched.
- rd may equal ra or rb, because operands are already staged.
- Flags are updated in WRITE for every op except LDI and NOP:
  - zero = (result == 0). For MUL the result is the full product; for DIV it is the quotient.
  - carry = carry-out of ra + rb for ADD, and carry-out of ra + ~rb + 1 for SUB (1 = no borrow). carry = 0 for all other ops.

## Timing
- With accept in cycle k:
  - LOAD_Y in k+1, EXEC in k+2, WRITE in k+3.
  - Writes land at the end of k+3.
  - done is registered and high in k+4, in IDLE with cmd_ready = 1; a back-to-back accept in k+4 is legal.
- DIV: DIV_ITER runs k+2 … k+1+WIDTH, WRITE in k+2+WIDTH, done in k+3+WIDTH (k+35 at WIDTH = 32).
- Throughput: one command per 4 cycles, or per WIDTH+3 cycles for DIV.
- Reset values: state IDLE, cmd_ready = 1, done = 0, and every R, Y, Z, HI, LO, carry, zero and the divider counter all 0.
- clr mid-command aborts immediately: no partial write, no done; cmd_ready = 1 on the first edge after clr deasserts.
- dbg_data is combinational and shows writes from the cycle after WRITE.

## Structure
- Shared package seq_datapath_pkg holds:
  - the opcode enum and the state enum;
  - the NOP range constant;
  - the divide-by-zero quotient constant.
- Sub-module div_iter(WIDTH):
  - start/busy/done interface, signed operands in, quotient/remainder out;
  - exactly WIDTH busy cycles; reset by clr.
- The ALU stays combinational inside the top.

## Test plan
- Reset: pulse clr → cmd_ready = 1, done = 0, hi = lo = 0, dbg_data = 0 for all NREGS indices.
- LDI R1 = 5, LDI R2 = 3, ADD R3 = R1 + R2 → R3 = 8, done exactly 4 cycles after accept, carry = 0, zero = 0; back-to-back accept in the done cycle succeeds.
- ADD 0xFFFFFFFF + 1 → 0, carry = 1, zero = 1. SUB 3 − 5 → 0xFFFFFFFE, carry = 0.
- MUL −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV 100 / 7 → LO = 14, HI = 2, done at k+35.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV 100 / 0 → LO = 0xFFFFFFFF, HI = 100.
- Shifts and rotates:
  - ROL 0x80000001 by 1 → 0x00000003.
  - SHRA 0x80000000 by 4 → 0xF8000000.
  - SHL 1 by 33 → 2, since the amount uses the low 5 bits.
- clr asserted at cycle k+10 of a DIV → no done, rd/HI/LO stay 0, cmd_ready = 1 after release.
- cmd_valid held during EXEC is not accepted.
